// File: rtl/multiboot_ctrl.sv
// Warmboot sequencer: detach USB, set up S1/S0, then strobe SB_WARMBOOT BOOT.
// Ports:
//   clk_48mhz, reset (async, active-high)
//   boot_req, boot_sel[1:0]   boot request and image index
//   usb_activity              restarts the idle timer (MULTIBOOT_TIMEOUT_EN)
//   usb_pu                    D+ pull-up enable, 0 = detached
//   wb_s1, wb_s0, wb_boot     SB_WARMBOOT controls
//   busy                      high whenever the state is not IDLE
// Build option: define MULTIBOOT_TIMEOUT_EN to auto-boot DEFAULT_IMAGE
// after TIMEOUT_CYCLES idle cycles without USB activity.
module multiboot_ctrl #(
  parameter int NUM_IMAGES     = 4,
  parameter int DEFAULT_IMAGE  = 1,
  parameter int DETACH_CYCLES  = 48000,
  parameter int SETUP_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 48000000
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       boot_req,
  input  logic [1:0] boot_sel,
  input  logic       usb_activity,
  output logic       usb_pu,
  output logic       wb_s1,
  output logic       wb_s0,
  output logic       wb_boot,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    DETACH,
    ARM,
    BOOT
  } state_t;

  localparam logic [1:0] DEF_IMG = 2'(DEFAULT_IMAGE);

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [1:0]  img, img_n;
  logic        start;
  logic [1:0]  sel_img;
  logic        pu_n, boot_n, busy_n;
  logic [1:0]  s_n;

`ifdef MULTIBOOT_TIMEOUT_EN
  logic [31:0] idle_cnt, idle_n;
  logic        timeout_hit;

  // Fires on the edge that would make the count reach TIMEOUT_CYCLES;
  // activity in the same cycle takes precedence.
  assign timeout_hit = !usb_activity &&
                       (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign start = boot_req || timeout_hit;
`else
  logic unused_activity;
  assign unused_activity = usb_activity;
  assign start = boot_req;
`endif

  // A timeout-only start has boot_req low, so it picks DEFAULT_IMAGE.
  assign sel_img = (boot_req && ({1'b0, boot_sel} < 3'(NUM_IMAGES)))
                 ? boot_sel : DEF_IMG;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    img_n   = img;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = DETACH;
          cnt_n   = 32'(DETACH_CYCLES - 1);
          img_n   = sel_img;
        end
      end
      DETACH: begin
        if (cnt == '0) begin
          state_n = ARM;
          cnt_n   = 32'(SETUP_CYCLES - 1);
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      ARM: begin
        if (cnt == '0) begin
          state_n = BOOT;
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      BOOT: begin
        cnt_n = '0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so they
    // change together with the state and have no input-to-output path.
    pu_n   = (state_n == IDLE);
    boot_n = (state_n == BOOT);
    busy_n = (state_n != IDLE);
    s_n    = ((state_n == ARM) || (state_n == BOOT)) ? img_n : DEF_IMG;
  end

`ifdef MULTIBOOT_TIMEOUT_EN
  always_comb begin
    idle_n = '0;
    if ((state == IDLE) && (state_n == IDLE) && !usb_activity) begin
      idle_n = idle_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_n;
    end
  end
`endif

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      img            <= DEF_IMG;
      usb_pu         <= 1'b1;
      wb_boot        <= 1'b0;
      busy           <= 1'b0;
      {wb_s1, wb_s0} <= DEF_IMG;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      img            <= img_n;
      usb_pu         <= pu_n;
      wb_boot        <= boot_n;
      busy           <= busy_n;
      {wb_s1, wb_s0} <= s_n;
    end
  end

endmodule

// File: tb/tb_multiboot_ctrl.sv
// Self-checking bench for multiboot_ctrl.
// Two instances: NUM_IMAGES=4 (dut_a) and NUM_IMAGES=2 (dut_b).
module tb_multiboot_ctrl;

  localparam int D = 4;
  localparam int S = 2;
  localparam int T = 20;
  localparam logic [1:0] DEF = 2'd1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       boot_req = 1'b0;
  logic [1:0] boot_sel = 2'd0;
  logic       usb_activity = 1'b0;

  logic a_pu, a_s1, a_s0, a_boot, a_busy;
  logic b_pu, b_s1, b_s0, b_boot, b_busy;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multiboot_ctrl #(
    .NUM_IMAGES(4), .DEFAULT_IMAGE(1), .DETACH_CYCLES(D),
    .SETUP_CYCLES(S), .TIMEOUT_CYCLES(T)
  ) dut_a (
    .clk_48mhz(clk), .reset(reset), .boot_req(boot_req),
    .boot_sel(boot_sel), .usb_activity(usb_activity),
    .usb_pu(a_pu), .wb_s1(a_s1), .wb_s0(a_s0),
    .wb_boot(a_boot), .busy(a_busy)
  );

  multiboot_ctrl #(
    .NUM_IMAGES(2), .DEFAULT_IMAGE(1), .DETACH_CYCLES(D),
    .SETUP_CYCLES(S), .TIMEOUT_CYCLES(T)
  ) dut_b (
    .clk_48mhz(clk), .reset(reset), .boot_req(boot_req),
    .boot_sel(boot_sel), .usb_activity(usb_activity),
    .usb_pu(b_pu), .wb_s1(b_s1), .wb_s0(b_s0),
    .wb_boot(b_boot), .busy(b_busy)
  );

  wire [4:0] obs_a = {a_pu, a_s1, a_s0, a_boot, a_busy};
  wire [4:0] obs_b = {b_pu, b_s1, b_s0, b_boot, b_busy};

  // Reference: k = cycles since the edge that started the boot.
  // Returns {usb_pu, s1, s0, wb_boot, busy}.
  function automatic logic [4:0] exp_out(int k, logic [1:0] img);
    if (k <= 0)         return {1'b1, DEF, 1'b0, 1'b0};
    else if (k <= D)    return {1'b0, DEF, 1'b0, 1'b1};
    else if (k <= D+S)  return {1'b0, img, 1'b0, 1'b1};
    else                return {1'b0, img, 1'b1, 1'b1};
  endfunction

  function automatic logic [1:0] img_for(logic [1:0] sel, int n);
    return (int'(sel) < n) ? sel : DEF;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    boot_req = 1'b0;
    usb_activity = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    logic [4:0] e;
    reset = 1'b1;
    tick();
    e = exp_out(0, DEF);
    checks++;
    if (obs_a !== e) begin
      fails++;
      $display("FAIL reset_a got=%b exp=%b", obs_a, e);
    end
    checks++;
    if (obs_b !== e) begin
      fails++;
      $display("FAIL reset_b got=%b exp=%b", obs_b, e);
    end
  endtask

  task automatic test_basic(logic [1:0] sel);
    logic [4:0] ea, eb;
    do_reset();
    boot_req = 1'b1;
    boot_sel = sel;
    tick();
    boot_req = 1'b0;
    for (int k = 1; k <= D + S + 4; k++) begin
      ea = exp_out(k, img_for(sel, 4));
      eb = exp_out(k, img_for(sel, 2));
      checks++;
      if (obs_a !== ea) begin
        fails++;
        $display("FAIL basic_a sel=%0d k=%0d got=%b exp=%b",
                 sel, k, obs_a, ea);
      end
      checks++;
      if (obs_b !== eb) begin
        fails++;
        $display("FAIL basic_b sel=%0d k=%0d got=%b exp=%b",
                 sel, k, obs_b, eb);
      end
      tick();
    end
  endtask

  task automatic test_reset_abort;
    logic [4:0] e;
    do_reset();
    boot_req = 1'b1;
    boot_sel = 2'd2;
    tick();
    boot_req = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    e = exp_out(0, DEF);
    checks++;
    if (obs_a !== e) begin
      fails++;
      $display("FAIL abort_now_a got=%b exp=%b", obs_a, e);
    end
    checks++;
    if (obs_b !== e) begin
      fails++;
      $display("FAIL abort_now_b got=%b exp=%b", obs_b, e);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      checks++;
      if (obs_a !== e || obs_b !== e) begin
        fails++;
        $display("FAIL abort_after c=%0d got=%b/%b exp=%b",
                 c, obs_a, obs_b, e);
      end
      tick();
    end
  endtask

  task automatic test_ignore_in_arm;
    logic [4:0] ea;
    do_reset();
    boot_req = 1'b1;
    boot_sel = 2'd2;
    tick();
    boot_req = 1'b0;
    for (int k = 1; k <= D + S + 3; k++) begin
      boot_req = (k == D + 1);
      usb_activity = (k == D + 1);
      if (k == D + 1) boot_sel = 2'd0;
      ea = exp_out(k, 2'd2);
      checks++;
      if (obs_a !== ea) begin
        fails++;
        $display("FAIL arm_ignore k=%0d got=%b exp=%b", k, obs_a, ea);
      end
      tick();
    end
    boot_req = 1'b0;
    usb_activity = 1'b0;
  endtask

  task automatic test_random;
    logic [1:0] sel;
    logic [4:0] ea, eb;
    int w;
    for (int it = 0; it < 20; it++) begin
      do_reset();
      w = $urandom_range(0, 5);
      for (int c = 0; c < w; c++) begin
        usb_activity = 1'($urandom);
        boot_sel = 2'($urandom);
        ea = exp_out(0, DEF);
        checks++;
        if (obs_a !== ea || obs_b !== ea) begin
          fails++;
          $display("FAIL rand_idle it=%0d got=%b/%b exp=%b",
                   it, obs_a, obs_b, ea);
        end
        tick();
      end
      sel = 2'($urandom);
      boot_req = 1'b1;
      boot_sel = sel;
      tick();
      for (int k = 1; k <= D + S + 3; k++) begin
        boot_req = 1'($urandom);
        boot_sel = 2'($urandom);
        usb_activity = 1'($urandom);
        ea = exp_out(k, img_for(sel, 4));
        eb = exp_out(k, img_for(sel, 2));
        checks++;
        if (obs_a !== ea || obs_b !== eb) begin
          fails++;
          $display("FAIL rand it=%0d sel=%0d k=%0d got=%b/%b exp=%b/%b",
                   it, sel, k, obs_a, obs_b, ea, eb);
        end
        tick();
      end
      boot_req = 1'b0;
      usb_activity = 1'b0;
    end
  endtask

`ifdef MULTIBOOT_TIMEOUT_EN
  // start = first DETACH cycle after reset release; act/req drive cycles.
  task automatic test_timeout(string name, int start, int act_c,
                              int req_c, logic [1:0] sel);
    logic [4:0] ea, eb;
    logic [1:0] ia, ib;
    ia = (req_c >= 0) ? img_for(sel, 4) : DEF;
    ib = (req_c >= 0) ? img_for(sel, 2) : DEF;
    do_reset();
    for (int c = 0; c <= start + D + S + 2; c++) begin
      usb_activity = (c == act_c);
      boot_req = (c == req_c);
      boot_sel = sel;
      ea = exp_out(c - start + 1, ia);
      eb = exp_out(c - start + 1, ib);
      checks++;
      if (obs_a !== ea || obs_b !== eb) begin
        fails++;
        $display("FAIL %s c=%0d got=%b/%b exp=%b/%b",
                 name, c, obs_a, obs_b, ea, eb);
      end
      tick();
    end
    usb_activity = 1'b0;
    boot_req = 1'b0;
  endtask
`else
  task automatic test_no_timeout;
    logic [4:0] e;
    do_reset();
    e = exp_out(0, DEF);
    for (int c = 0; c < 3 * T; c++) begin
      usb_activity = 1'($urandom);
      checks++;
      if (obs_a !== e || obs_b !== e) begin
        fails++;
        $display("FAIL no_timeout c=%0d got=%b/%b exp=%b",
                 c, obs_a, obs_b, e);
      end
      tick();
    end
    usb_activity = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_basic(2'd2);
    test_basic(2'd3);
    test_basic(2'd0);
    test_reset_abort();
    test_ignore_in_arm();
    test_random();
`ifdef MULTIBOOT_TIMEOUT_EN
    test_timeout("timeout_plain", T, -1, -1, 2'd0);
    test_timeout("timeout_act15", 36, 15, -1, 2'd0);
    test_timeout("timeout_req", T, -1, T - 1, 2'd3);
    test_timeout("timeout_act_wins", 2 * T, T - 1, -1, 2'd0);
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/multiboot_ctrl.md
MULTIBOOT_CTRL -- requirements
Module: multiboot_ctrl

Interface
REQ-001 Parameter NUM_IMAGES, default 4, number of selectable warmboot images (1..4).
REQ-002 Parameter DEFAULT_IMAGE, default 1, image used for timeout boots and out-of-range selects; SHALL be < NUM_IMAGES.
REQ-003 Parameter DETACH_CYCLES, default 48000, USB detach hold time in clk_48mhz cycles (1 ms); minimum 1.
REQ-004 Parameter SETUP_CYCLES, default 16, S1/S0 setup time before BOOT assertion; minimum 1.
REQ-005 Parameter TIMEOUT_CYCLES, default 48000000, idle time before auto-boot (1 s); counter width 32 bits.
REQ-006 clk_48mhz  input  1  sole clock, 48 MHz from the USB PLL.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 boot_req  input  1  single-cycle boot request from the bootloader core.
REQ-009 boot_sel  input  2  requested image index, sampled with boot_req.
REQ-010 usb_activity  input  1  pulse on any valid USB packet; restarts idle timer.
REQ-011 usb_pu  output  1  USB D+ pull-up enable; 0 = detached.
REQ-012 wb_s1, wb_s0  output  1 each  image select to SB_WARMBOOT S1/S0.
REQ-013 wb_boot  output  1  SB_WARMBOOT BOOT strobe.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, DETACH, ARM, BOOT; each state change occurs on a rising clk_48mhz edge.
REQ-016 IDLE: usb_pu=1, wb_boot=0, busy=0; boot_req=1 -> latch image, load counter, go DETACH next cycle.
REQ-017 Latched image = boot_sel if boot_sel < NUM_IMAGES, else DEFAULT_IMAGE.
REQ-018 DETACH: usb_pu=0 for exactly DETACH_CYCLES cycles, then go ARM.
REQ-019 ARM: usb_pu=0, {wb_s1,wb_s0}=latched image, wb_boot=0 for exactly SETUP_CYCLES cycles, then go BOOT.
REQ-020 BOOT: usb_pu=0, wb_s1/wb_s0 held, wb_boot=1; terminal state, left only by reset.
REQ-021 {wb_s1,wb_s0} SHALL be stable from ARM entry through BOOT; in IDLE they equal DEFAULT_IMAGE.
REQ-022 boot_req, boot_sel and usb_activity SHALL be ignored outside IDLE; no re-latching.
REQ-023 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-024 First usb_pu=0 cycle SHALL be the cycle after the boot_req sample edge (latency 1).

Reset
REQ-025 reset=1 SHALL immediately force IDLE, usb_pu=1, wb_boot=0, busy=0, {wb_s1,wb_s0}=DEFAULT_IMAGE, all counters 0, regardless of state.
REQ-026 Reset asserted mid-DETACH or mid-ARM SHALL abort the sequence; no BOOT strobe results.
REQ-027 After reset release, first boot_req is honoured on the first rising edge.

Configuration
REQ-028 Macro MULTIBOOT_TIMEOUT_EN defined: in IDLE a 32-bit idle counter increments each cycle, clears on usb_activity=1, and on reaching TIMEOUT_CYCLES starts a boot to DEFAULT_IMAGE exactly as a boot_req.
REQ-029 Same-cycle boot_req and timeout: boot_req wins, boot_sel honoured; usb_activity and timeout in the same cycle: activity wins, no boot.
REQ-030 Idle counter SHALL clear on reset and on leaving IDLE; it never wraps.
REQ-031 Macro undefined: no idle counter synthesised; usb_activity is unused; only boot_req starts a boot.

Verification (bench parameters DETACH_CYCLES=4, SETUP_CYCLES=2, TIMEOUT_CYCLES=20)
REQ-032 boot_req=1, boot_sel=2 at cycle 0 -> usb_pu=0 cycles 1-4, {s1,s0}=10 from cycle 5, wb_boot=1 from cycle 7 onward.
REQ-033 NUM_IMAGES=2, boot_sel=3 -> latched image DEFAULT_IMAGE=1, {s1,s0}=01 at BOOT.
REQ-034 Reset pulsed in cycle 3 of DETACH -> usb_pu=1, busy=0 same cycle; wb_boot never asserts.
REQ-035 Second boot_req with boot_sel=0 during ARM -> ignored; BOOT uses first image.
REQ-036 MULTIBOOT_TIMEOUT_EN defined, no activity -> boot to image 1 starts after 20 idle cycles; activity pulse at cycle 15 delays start to cycle 36.
REQ-037 MULTIBOOT_TIMEOUT_EN defined, boot_req with boot_sel=3 on timeout cycle -> image 3 booted.
